// File: rtl/rect_bounce_ctl.sv
// rtl/rect_bounce_ctl.sv - mouse-tracking rectangle position controller with gravity fall and damped floor bounce
module rect_bounce_ctl #(
    parameter int TICK_DIV   = 400_000,
    parameter int RECT_W     = 48,
    parameter int RECT_H     = 64,
    parameter int SCREEN_W   = 800,
    parameter int SCREEN_H   = 600,
    parameter int GRAVITY    = 1,
    parameter int VMAX       = 31,
    parameter int DAMP_SHIFT = 2,
    parameter int MIN_BOUNCE = 2
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        mouse_left,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        moving
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [11:0] XMAX    = 12'(SCREEN_W - RECT_W);
    localparam logic [11:0] FLOOR_Y = 12'(SCREEN_H - RECT_H);
    localparam logic [6:0]  GRAV7   = 7'(GRAVITY);
    localparam logic [6:0]  VMAX7   = 7'(VMAX);
    localparam logic [5:0]  GRAV6   = 6'(GRAVITY);
    localparam logic [5:0]  MINB6   = 6'(MIN_BOUNCE);

    typedef enum logic [1:0] {S_IDLE, S_FALL, S_RISE, S_REST} state_t;

    state_t           state_q, state_d;
    logic [5:0]       vel_q, vel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             left_d_q, left_d_d;
    logic [11:0]      xpos_q, xpos_d;
    logic [11:0]      ypos_q, ypos_d;
    logic             moving_q, moving_d;

    logic        tick;
    logic        click;
    logic [6:0]  v1_sum;
    logic [5:0]  v1;
    logic [12:0] yn;
    logic [5:0]  vb;

    always_comb begin
        tick   = (cnt_q == CNT_LAST);
        click  = mouse_left & ~left_d_q;
        v1_sum = {1'b0, vel_q} + GRAV7;
        v1     = (v1_sum > VMAX7) ? VMAX7[5:0] : v1_sum[5:0];
        // 13-bit sum so a fast fall near the top of the 12-bit range still clamps
        yn     = {1'b0, ypos_q} + {7'd0, v1};
        vb     = v1 - (v1 >> DAMP_SHIFT);

        state_d  = state_q;
        vel_d    = vel_q;
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        left_d_d = mouse_left;
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;

        case (state_q)
            S_IDLE: begin
                xpos_d = (mouse_xpos > XMAX) ? XMAX : mouse_xpos;
                ypos_d = (mouse_ypos > FLOOR_Y) ? FLOOR_Y : mouse_ypos;
                if (click) begin
                    state_d = S_FALL;
                    vel_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_FALL: begin
                if (tick) begin
                    if (yn < {1'b0, FLOOR_Y}) begin
                        ypos_d = yn[11:0];
                        vel_d  = v1;
                    end else begin
                        ypos_d = FLOOR_Y;
                        if (vb < MINB6) begin
                            state_d = S_REST;
                            vel_d   = '0;
                        end else begin
                            state_d = S_RISE;
                            vel_d   = vb;
                        end
                    end
                end
            end
            S_RISE: begin
                if (tick) begin
                    ypos_d = (ypos_q > {6'd0, vel_q}) ? ypos_q - {6'd0, vel_q} : '0;
                    if (vel_q <= GRAV6) begin
                        vel_d   = '0;
                        state_d = S_FALL;
                    end else begin
                        vel_d = vel_q - GRAV6;
                    end
                end
            end
            S_REST: begin
                if (click) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        moving_d = (state_d == S_FALL) || (state_d == S_RISE);
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            vel_q    <= '0;
            cnt_q    <= '0;
            left_d_q <= 1'b0;
            xpos_q   <= '0;
            ypos_q   <= '0;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            vel_q    <= vel_d;
            cnt_q    <= cnt_d;
            left_d_q <= left_d_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            moving_q <= moving_d;
        end
    end

    assign xpos   = xpos_q;
    assign ypos   = ypos_q;
    assign moving = moving_q;

endmodule
